// File: rtl/pulser_pkg.sv
// Shared definitions for the pulser array: register map, channel modes,
// channel states and the per-channel control register layout.
package pulser_pkg;

  // Per-channel register offsets within a 0x10 channel window
  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_PERIOD = 4'h4;
  localparam logic [3:0] OFS_HIGH   = 4'h8;
  localparam logic [3:0] OFS_BURST  = 4'hC;

  // Global registers
  localparam logic [7:0] ADDR_START = 8'hF0;
  localparam logic [7:0] ADDR_DONE  = 8'hF4;

  typedef enum logic [1:0] {
    MODE_CONT    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_BURST   = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // CTRL layout: bit0 en, bits2:1 mode, bit3 pol, bit4 irq_en
  typedef struct packed {
    logic  irq_en;
    logic  pol;
    mode_e mode;
    logic  en;
  } ctrl_t;

  // True when the period that is wrapping right now is the last one
  function automatic logic last_period(input mode_e       mode,
                                       input logic [31:0] periods_done,
                                       input logic [31:0] burst);
    logic [31:0] target;
    target = (burst == '0) ? 32'd1 : burst;
    case (mode)
      MODE_ONESHOT: last_period = 1'b1;
      MODE_BURST:   last_period = (periods_done + 32'd1) >= target;
      default:      last_period = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pulser_channel.sv
// One pulse channel: CTRL/PERIOD/HIGH/BURST registers, shadowed period and
// high values, period counter and IDLE/RUN/DONE state machine.
module pulser_channel
  import pulser_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ctrl_we,
  input  logic                period_we,
  input  logic                high_we,
  input  logic                burst_we,
  input  ctrl_t               wdata_ctrl,
  input  logic [CntWidth-1:0] wdata_cnt,
  input  logic                start,
  output ctrl_t               ctrl,
  output logic [CntWidth-1:0] period,
  output logic [CntWidth-1:0] high,
  output logic [CntWidth-1:0] burst,
  output logic                done,
  output logic                pulse
);

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  ctrl_t               ctrl_q, ctrl_n;
  logic [CntWidth-1:0] period_q, high_q, burst_q;
  logic [CntWidth-1:0] cnt_q, cnt_n;
  logic [CntWidth-1:0] per_sh_q, per_sh_n;
  logic [CntWidth-1:0] high_sh_q, high_sh_n;
  logic [CntWidth-1:0] bcnt_q, bcnt_n;
  state_e              state_q, state_n;
  logic                pulse_n;
  logic                done_evt;
  logic                start_req;
  logic                stop_req;
  logic                wrap;

  // Next-state, counter and shadow update; pulse level derived from next state
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    per_sh_n  = per_sh_q;
    high_sh_n = high_sh_q;
    bcnt_n    = bcnt_q;
    ctrl_n    = ctrl_q;
    done_evt  = 1'b0;
    stop_req  = ctrl_we & ~wdata_ctrl.en;
    start_req = (ctrl_we & wdata_ctrl.en & ~ctrl_q.en) |
                (start & ctrl_q.en & ~stop_req);
    wrap      = (cnt_q == per_sh_q - CntOne);
    if (ctrl_we) ctrl_n = wdata_ctrl;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A CTRL write leaves DONE; an en 0->1 in that same write starts at once
        if (ctrl_we) state_n = ST_IDLE;
        if (start_req && (period_q != '0)) begin
          state_n   = ST_RUN;
          cnt_n     = '0;
          per_sh_n  = period_q;
          high_sh_n = high_q;
          bcnt_n    = '0;
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (wrap) begin
          cnt_n     = '0;
          per_sh_n  = period_q;
          high_sh_n = high_q;
          bcnt_n    = bcnt_q + CntOne;
          if (last_period(ctrl_q.mode, 32'(bcnt_q), 32'(burst_q))) begin
            state_n   = ST_DONE;
            done_evt  = 1'b1;
            ctrl_n.en = 1'b0;
          end else if (period_q == '0) begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt_q + CntOne;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    pulse_n = ctrl_n.pol ^ ((state_n == ST_RUN) && (cnt_n < high_sh_n));
  end

  // Register file, FSM state and registered pulse output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      per_sh_q  <= '0;
      high_sh_q <= '0;
      bcnt_q    <= '0;
      state_q   <= ST_IDLE;
      pulse     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_n;
      if (period_we) period_q <= wdata_cnt;
      if (high_we)   high_q   <= wdata_cnt;
      if (burst_we)  burst_q  <= wdata_cnt;
      cnt_q     <= cnt_n;
      per_sh_q  <= per_sh_n;
      high_sh_q <= high_sh_n;
      bcnt_q    <= bcnt_n;
      state_q   <= state_n;
      pulse     <= pulse_n;
    end
  end

  assign ctrl   = ctrl_q;
  assign period = period_q;
  assign high   = high_q;
  assign burst  = burst_q;
  assign done   = done_evt;

endmodule

// File: rtl/pulser_array.sv
// Array of independent pulse channels behind a simple register port, with
// global START and write-1-to-clear DONE registers and a level interrupt.
module pulser_array
  import pulser_pkg::*;
#(
  parameter int unsigned NumCh    = 8,
  parameter int unsigned CntWidth = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             reg_req_i,
  input  logic             reg_we_i,
  input  logic [7:0]       reg_addr_i,
  input  logic [31:0]      reg_wdata_i,
  output logic [31:0]      reg_rdata_o,
  output logic             reg_rvalid_o,
  output logic [NumCh-1:0] pulse_o,
  output logic             irq_o
);

  logic                wr, rd;
  logic [7:0]          word_addr;
  logic [3:0]          reg_ofs;
  logic                start_wr, done_wr;
  ctrl_t               ctrl_rd   [NumCh];
  logic [CntWidth-1:0] period_rd [NumCh];
  logic [CntWidth-1:0] high_rd   [NumCh];
  logic [CntWidth-1:0] burst_rd  [NumCh];
  logic [NumCh-1:0]    done_evt;
  logic [NumCh-1:0]    irq_en;
  logic [NumCh-1:0]    done_q;
  logic [NumCh-1:0]    w1c_mask;
  logic                irq_q;
  logic [31:0]         rdata_q, rdata_n;
  logic                rvalid_q;
  logic                unused_bits;

  assign wr          = reg_req_i & reg_we_i;
  assign rd          = reg_req_i & ~reg_we_i;
  assign word_addr   = {reg_addr_i[7:2], 2'b00};
  assign reg_ofs     = {reg_addr_i[3:2], 2'b00};
  assign start_wr    = wr && (word_addr == ADDR_START);
  assign done_wr     = wr && (word_addr == ADDR_DONE);
  assign w1c_mask    = done_wr ? reg_wdata_i[NumCh-1:0] : '0;
  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic sel;
    assign sel = wr && (reg_addr_i[7:4] == 4'(c));

    pulser_channel #(
      .CntWidth(CntWidth)
    ) u_ch (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .ctrl_we   (sel && (reg_ofs == OFS_CTRL)),
      .period_we (sel && (reg_ofs == OFS_PERIOD)),
      .high_we   (sel && (reg_ofs == OFS_HIGH)),
      .burst_we  (sel && (reg_ofs == OFS_BURST)),
      .wdata_ctrl(ctrl_t'(reg_wdata_i[4:0])),
      .wdata_cnt (reg_wdata_i[CntWidth-1:0]),
      .start     (start_wr & reg_wdata_i[c]),
      .ctrl      (ctrl_rd[c]),
      .period    (period_rd[c]),
      .high      (high_rd[c]),
      .burst     (burst_rd[c]),
      .done      (done_evt[c]),
      .pulse     (pulse_o[c])
    );

    assign irq_en[c] = ctrl_rd[c].irq_en;
  end

  // Read data mux; unmapped addresses and START read as zero
  always_comb begin
    rdata_n = '0;
    if (word_addr == ADDR_DONE) rdata_n = 32'(done_q);
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (reg_addr_i[7:4] == 4'(c)) begin
        case (reg_ofs)
          OFS_CTRL:   rdata_n = {27'b0, ctrl_rd[c]};
          OFS_PERIOD: rdata_n = 32'(period_rd[c]);
          OFS_HIGH:   rdata_n = 32'(high_rd[c]);
          OFS_BURST:  rdata_n = 32'(burst_rd[c]);
          default:    rdata_n = '0;
        endcase
      end
    end
  end

  // DONE flags (set beats clear), registered interrupt and read response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q   <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      done_q   <= (done_q & ~w1c_mask) | done_evt;
      irq_q    <= |(done_q & irq_en);
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_n;
    end
  end

  assign reg_rdata_o  = rdata_q;
  assign reg_rvalid_o = rvalid_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_pulser_array.sv
// Directed self-checking bench for pulser_array.
module tb_pulser_array;

  logic        clk;
  logic        rst_ni;
  logic        reg_req_i;
  logic        reg_we_i;
  logic [7:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_rvalid_o;
  logic [7:0]  pulse_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_err = 0;

  pulser_array #(
    .NumCh   (8),
    .CntWidth(16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .reg_req_i   (reg_req_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_rvalid_o(reg_rvalid_o),
    .pulse_o     (pulse_o),
    .irq_o       (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the following negedge
  task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
    reg_req_i   = 1'b1;
    reg_we_i    = 1'b1;
    reg_addr_i  = addr;
    reg_wdata_i = data;
    @(negedge clk);
    reg_req_i   = 1'b0;
    reg_we_i    = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    reg_req_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = addr;
    @(negedge clk);
    reg_req_i  = 1'b0;
    check_eq({tag, "_rvalid"}, 32'(reg_rvalid_o), 32'd1);
    check_eq(tag, reg_rdata_o, exp);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs, exp, obs1, exp1, acc;

    rst_ni      = 1'b0;
    reg_req_i   = 1'b0;
    reg_we_i    = 1'b0;
    reg_addr_i  = '0;
    reg_wdata_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_pulse", 32'(pulse_o), 32'h0);
    check_eq("rst_irq", 32'(irq_o), 32'h0);
    check_eq("rst_rvalid", 32'(reg_rvalid_o), 32'h0);
    check_eq("rst_rdata", reg_rdata_o, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk);
    reg_read(8'h04, 32'h0, "rst_period0");
    reg_read(8'h80, 32'h0, "unmapped_80");
    reg_read(8'hF8, 32'h0, "unmapped_F8");

    // ch0 continuous PERIOD=10 HIGH=3
    reg_write(8'h04, 32'd10);
    reg_write(8'h08, 32'd3);
    reg_write(8'h00, 32'h01);
    obs = '0; exp = '0;
    for (int i = 0; i < 20; i++) begin
      obs[i] = pulse_o[0];
      exp[i] = (i % 10) < 3;
      @(negedge clk);
    end
    check_eq("ch0_cont_pattern", obs, exp);
    check_eq("ch0_cont_noirq", 32'(irq_o), 32'h0);
    reg_write(8'h00, 32'h00);
    check_eq("ch0_stop_pulse", 32'(pulse_o), 32'h0);
    reg_read(8'hF4, 32'h0, "ch0_stop_nodone");

    // ch1 burst of 3, PERIOD=4 HIGH=2, irq enabled
    reg_write(8'h14, 32'd4);
    reg_write(8'h18, 32'd2);
    reg_write(8'h1C, 32'd3);
    reg_write(8'h10, 32'h15);
    obs = '0; exp = '0;
    for (int i = 0; i < 12; i++) begin
      obs[i] = pulse_o[1];
      exp[i] = (i % 4) < 2;
      @(negedge clk);
    end
    check_eq("ch1_burst_pattern", obs, exp);
    check_eq("ch1_done_pulse", 32'(pulse_o), 32'h0);
    check_eq("ch1_irq_not_yet", 32'(irq_o), 32'h0);
    @(negedge clk);
    check_eq("ch1_irq_set", 32'(irq_o), 32'h1);
    reg_read(8'hF4, 32'h02, "ch1_done_reg");
    reg_read(8'h10, 32'h14, "ch1_en_cleared");
    reg_write(8'hF4, 32'h02);
    @(negedge clk);
    check_eq("ch1_irq_cleared", 32'(irq_o), 32'h0);
    reg_read(8'hF4, 32'h0, "ch1_done_cleared");

    // ch2 one-shot, pol=1, PERIOD=5 HIGH=1
    reg_write(8'h24, 32'd5);
    reg_write(8'h28, 32'd1);
    reg_write(8'h20, 32'h0B);
    obs = '0;
    for (int i = 0; i < 5; i++) begin
      obs[i] = pulse_o[2];
      @(negedge clk);
    end
    check_eq("ch2_oneshot_pattern", obs, 32'h1E);
    check_eq("ch2_done_level", 32'(pulse_o[2]), 32'h1);
    reg_read(8'hF4, 32'h04, "ch2_done_reg");
    reg_read(8'h20, 32'h0A, "ch2_en_cleared");
    reg_write(8'hF4, 32'h04);
    reg_write(8'h20, 32'h00);
    check_eq("ch2_pol_restored", 32'(pulse_o[2]), 32'h0);

    // ch3 PERIOD=0 never starts
    reg_write(8'h30, 32'h01);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | 32'(pulse_o);
      @(negedge clk);
    end
    reg_write(8'hF0, 32'h08);
    for (int i = 0; i < 4; i++) begin
      acc = acc | 32'(pulse_o);
      @(negedge clk);
    end
    check_eq("ch3_period0_idle", acc, 32'h0);
    reg_read(8'h30, 32'h01, "ch3_ctrl");
    reg_read(8'hF0, 32'h0, "start_reads0");
    reg_read(8'hF4, 32'h0, "ch3_nodone");
    reg_write(8'h30, 32'h00);

    // ch0 PERIOD 8 -> 4 written at count 2
    reg_write(8'h04, 32'd8);
    reg_write(8'h00, 32'h01);
    obs = '0; exp = '0;
    for (int i = 0; i < 20; i++) begin
      obs[i] = pulse_o[0];
      exp[i] = (i < 8) ? (i < 3) : (((i - 8) % 4) < 3);
      if (i == 2) reg_write(8'h04, 32'd4);
      else @(negedge clk);
    end
    check_eq("ch0_shadow_pattern", obs, exp);
    reg_write(8'h00, 32'h00);

    // ch0/ch1 started together from START
    reg_write(8'h04, 32'd0);
    reg_write(8'h08, 32'd2);
    reg_write(8'h00, 32'h01);
    reg_write(8'h14, 32'd0);
    reg_write(8'h18, 32'd2);
    reg_write(8'h10, 32'h01);
    reg_write(8'h04, 32'd6);
    reg_write(8'h14, 32'd6);
    check_eq("start_pre_idle", 32'(pulse_o), 32'h0);
    reg_write(8'hF0, 32'h03);
    obs = '0; exp = '0; obs1 = '0; exp1 = '0;
    for (int i = 0; i < 12; i++) begin
      obs[i]  = pulse_o[0];
      obs1[i] = pulse_o[1];
      exp[i]  = (i % 6) < 2;
      exp1[i] = (i % 6) < 2;
      @(negedge clk);
    end
    check_eq("start_ch0_pattern", obs, exp);
    check_eq("start_ch1_pattern", obs1, exp1);

    // reset in the middle of a ch1 burst
    reg_write(8'h10, 32'h00);
    reg_write(8'h14, 32'd4);
    reg_write(8'h18, 32'd2);
    reg_write(8'h1C, 32'd3);
    reg_write(8'h10, 32'h15);
    check_eq("ch1_burst_running", 32'(pulse_o[1]), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("async_rst_pulse", 32'(pulse_o), 32'h0);
    check_eq("async_rst_irq", 32'(irq_o), 32'h0);
    check_eq("async_rst_rvalid", 32'(reg_rvalid_o), 32'h0);
    check_eq("async_rst_rdata", reg_rdata_o, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc = acc | 32'(pulse_o);
      @(negedge clk);
    end
    check_eq("post_rst_idle", acc, 32'h0);
    reg_read(8'h10, 32'h0, "post_rst_ch1_ctrl");
    reg_read(8'hF4, 32'h0, "post_rst_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
